serial_wide_adder: RTL
======================

SERIAL_WIDE_ADDER -- requirements
Module: serial_wide_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand set on a, b, cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_valid  output  1  result on sum/cout/ovf is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-014 busy  output  1  high in ADD state.

Function
REQ-015 NB = WIDTH/8; the addition SHALL be computed byte-serially, one 8-bit byte plus carry per clock, LSB byte first, with the byte carry registered and chained to the next byte.
REQ-016 The state machine SHALL have exactly three states: IDLE, ADD, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0, busy=0; on in_valid&&in_ready, latch a, b, cin; clear the byte index to 0; go to ADD.
REQ-018 ADD: in_ready=0, busy=1; each edge computes byte[idx] = a[idx]+b[idx]+carry, writes the byte into sum[8*idx+7:8*idx], updates carry, and increments idx.
REQ-019 The first ADD edge SHALL use the latched cin as carry.
REQ-020 On the edge processing byte NB-1, load cout with the final carry and ovf with the MSB carry-in XOR the final carry; go to DONE.
REQ-021 Latency: with acceptance on edge k, out_valid SHALL be high after edge k+NB.
REQ-022 DONE: out_valid=1, in_ready=0, busy=0; sum, cout and ovf SHALL hold stable while out_ready=0.
REQ-023 DONE, on out_valid&&out_ready: go to IDLE; out_valid=0 after that edge; sum/cout/ovf retain their values until the next acceptance.
REQ-024 in_valid while not in IDLE SHALL be ignored and SHALL NOT disturb the latched operands.
REQ-025 Changes on a/b/cin after acceptance SHALL NOT affect the result in flight.
REQ-026 No result-to-accept overlap: a new operand set SHALL only be accepted in IDLE, so minimum throughput is one result per NB+2 cycles.
REQ-027 Carry propagation SHALL be exact across byte boundaries, including a full-width ripple (all-ones + 1).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, idx=0, carry=0, and latched operands to 0.
REQ-029 Reset asserted mid-ADD or in DONE SHALL abort the operation with no result ever presented.
REQ-030 After rst_n deasserts, the first acceptance edge SHALL behave identically to the post-power-up case.

Verification (WIDTH=32)
REQ-031 a=0xFFFFFFFF, b=0x00000001, cin=0 accepted on edge k -> out_valid after edge k+4; sum=0x00000000, cout=1, ovf=0.
REQ-032 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-033 a=0x12345678, b=0x0FEDCBA8, cin=1 with out_ready held 0 for 5 cycles -> sum=0x22222221, cout=0 stable throughout; in_ready=0 until the out_ready handshake, then in_ready=1.
REQ-034 in_valid held high with changing a/b during ADD and DONE -> no second acceptance; result matches the originally accepted operands.
REQ-035 rst_n pulsed low after 2 ADD edges -> outputs zero immediately, out_valid never rises; next operand set 5+3, cin=0 -> sum=0x00000008.
REQ-036 Randomized back-to-back traffic (1000 sets, random out_ready) -> every result equals the reference model for a+b+cin, cout and ovf, in order with no drops.

Source files
------------

// File: rtl/serial_wide_adder.sv
// Byte-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// One byte per clock, LSB first, ripple carry held in a register between bytes.
`timescale 1ns/1ps
module serial_wide_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx_reg;
  logic [7:0]      sum_bytes_reg [NB];
  logic            cout_reg, ovf_reg;

  logic [7:0]      a_bytes [NB];
  logic [7:0]      b_bytes [NB];
  logic [8:0]      byte_sum;
  logic            last_byte;
  logic            msb_carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : gen_bytes
      assign a_bytes[gi]        = a_reg[8*gi +: 8];
      assign b_bytes[gi]        = b_reg[8*gi +: 8];
      assign sum[8*gi +: 8]     = sum_bytes_reg[gi];
    end
  endgenerate

  assign byte_sum  = {1'b0, a_bytes[idx_reg]} + {1'b0, b_bytes[idx_reg]} + {8'd0, carry_reg};
  assign last_byte = (idx_reg == IW'(NB - 1));
  // Carry into the MSB recovered from the sum bit: s7 = a7 ^ b7 ^ c7.
  assign msb_carry_in = a_bytes[idx_reg][7] ^ b_bytes[idx_reg][7] ^ byte_sum[7];

  assign cout = cout_reg;
  assign ovf  = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_byte) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < NB; i++) sum_bytes_reg[i] <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        ADD: begin
          sum_bytes_reg[idx_reg] <= byte_sum[7:0];
          carry_reg              <= byte_sum[8];
          idx_reg                <= idx_reg + 1'b1;
          if (last_byte) begin
            cout_reg <= byte_sum[8];
            ovf_reg  <= msb_carry_in ^ byte_sum[8];
            idx_reg  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
